// File: rtl/flag_xfer_scheduler_if.sv
// Handshake bundle between the flag scheduler and its requesters and downstream crossing.
// master drives requests, ready and ack; slave is the scheduler side.
interface flag_xfer_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req_clkA;
  logic            ready_to_get_more_data;
  logic            AckIn_clkA;
  logic            FlagIn_clkA;
  logic [IdW-1:0]  grant_id_clkA;
  logic [NREQ-1:0] done_clkA;
  logic            busy_clkA;
  logic            user_w_mydevice_full;
  logic [NREQ-1:0] coalesce_err_clkA;
  logic            timeout_err_clkA;

  modport master (
    output req_clkA, ready_to_get_more_data, AckIn_clkA,
    input  FlagIn_clkA, grant_id_clkA, done_clkA, busy_clkA, user_w_mydevice_full,
           coalesce_err_clkA, timeout_err_clkA
  );

  modport slave (
    input  req_clkA, ready_to_get_more_data, AckIn_clkA,
    output FlagIn_clkA, grant_id_clkA, done_clkA, busy_clkA, user_w_mydevice_full,
           coalesce_err_clkA, timeout_err_clkA
  );
endinterface

// File: rtl/flag_xfer_scheduler.sv
// Round-robin scheduler sharing one cross-domain flag pulse among NREQ requesters.
// Define FLAG_XFER_ACK_EN to finish transfers on a returned ack (with timeout) instead of HOLDOFF.
module flag_xfer_scheduler #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic                  clkA,
  input logic                  rst_clkA,
  flag_xfer_scheduler_if.slave bus
);
  localparam int unsigned IdW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntMax = (HOLDOFF > ACK_TIMEOUT) ? HOLDOFF : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StHold, StWaitAck} state_e;

  state_e          state_q;
  logic [NREQ-1:0] pending_q;
  logic [NREQ-1:0] coalesce_q;
  logic [NREQ-1:0] done_q;
  logic [IdW-1:0]  grant_id_q;
  logic [IdW-1:0]  last_q;
  logic [CntW-1:0] cnt_q;
  logic            flag_q;
  logic            full_q;

  logic [IdW-1:0]  winner;
  logic [IdW-1:0]  idx_w;
  logic            found;
  logic            grant;
  logic [NREQ-1:0] clr;
  int              idx;

  // Scan from the slot after the last winner so every requester gets a turn.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx   = (int'(last_q) + k) % int'(NREQ);
      idx_w = IdW'(idx);
      if (!found && pending_q[idx_w]) begin
        winner = idx_w;
        found  = 1'b1;
      end
    end
  end

  assign grant = (state_q == StIdle) && found && bus.ready_to_get_more_data;
  assign clr   = grant ? (NREQ'(1) << winner) : '0;

`ifdef FLAG_XFER_ACK_EN
  logic timeout_q;
`endif

  always_ff @(posedge clkA) begin
    if (rst_clkA) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      coalesce_q <= '0;
      done_q     <= '0;
      grant_id_q <= '0;
      last_q     <= IdW'(NREQ - 1);
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      full_q     <= 1'b1;
`ifdef FLAG_XFER_ACK_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      // A request landing on the clearing cycle re-arms the slot instead of being lost.
      pending_q  <= (pending_q & ~clr) | bus.req_clkA;
      coalesce_q <= coalesce_q | (bus.req_clkA & pending_q & ~clr);
      full_q     <= ~bus.ready_to_get_more_data | (&pending_q);
      flag_q     <= 1'b0;
      done_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
`ifdef FLAG_XFER_ACK_EN
            state_q    <= StWaitAck;
`else
            state_q    <= StHold;
`endif
            flag_q     <= 1'b1;
            grant_id_q <= winner;
            last_q     <= winner;
            cnt_q      <= '0;
          end
        end
        StHold: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(HOLDOFF - 1)) done_q <= NREQ'(1) << grant_id_q;
          if (cnt_q == CntW'(HOLDOFF)) state_q <= StIdle;
        end
`ifdef FLAG_XFER_ACK_EN
        StWaitAck: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.AckIn_clkA) begin
            done_q  <= NREQ'(1) << grant_id_q;
            state_q <= StIdle;
          end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
            done_q    <= NREQ'(1) << grant_id_q;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.FlagIn_clkA          = flag_q;
  assign bus.grant_id_clkA        = grant_id_q;
  assign bus.done_clkA            = done_q;
  assign bus.busy_clkA            = (state_q != StIdle);
  assign bus.user_w_mydevice_full = full_q;
  assign bus.coalesce_err_clkA    = coalesce_q;

`ifdef FLAG_XFER_ACK_EN
  assign bus.timeout_err_clkA = timeout_q;
`else
  logic unused_ack;
  assign unused_ack           = bus.AckIn_clkA;
  assign bus.timeout_err_clkA = 1'b0;
`endif
endmodule
